// File: rtl/sof_sync.sv
// Receive-side SOF framer: hunts the 26-symbol pi/2-BPSK SOF in the symbol stream and forwards
// the following PAYLOAD_LEN symbols. Define SOF_PHASE_INV_EN to also lock on a 180-deg inverted SOF.
module sof_sync #(
    parameter int W           = 12,
    parameter int PAYLOAD_LEN = 61,
    parameter int THRESH      = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_i,
    input  logic [W-1:0] in_q,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_i,
    output logic [W-1:0] out_q,
    output logic         out_sof,
    input  logic         out_ready,
    output logic         locked,
    output logic [5:0]   score
);

    localparam int          CNT_W = $clog2(PAYLOAD_LEN);
    localparam logic [25:0] SOF   = 26'h18D2E82;
    // Symbol k (k=0 sent first) sits at register bit 25-k; odd k means even bit index.
    localparam logic [25:0] EXP_I = SOF ^ 26'h1555555;

    typedef enum logic {ST_HUNT, ST_PAYLOAD} state_t;

    state_t           state_q;
    logic [25:0]      qsr_q, isr_q, qsr_d, isr_d;
    logic [4:0]       fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             out_valid_q, out_sof_q;
    logic [W-1:0]     out_i_q, out_q_q, pay_i, pay_q;
    logic [5:0]       score_q, match;
    logic             accept, sof_hit, inv_hit;

    function automatic logic [5:0] ones26(input logic [25:0] v);
        logic [5:0] c;
        c = '0;
        for (int k = 0; k < 26; k++) c += {5'd0, v[k]};
        return c;
    endfunction

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        in_ready = 1'b1;
        if (state_q == ST_PAYLOAD) in_ready = out_ready | ~out_valid_q;
    end

    assign accept  = in_valid & in_ready;
    assign qsr_d   = {qsr_q[24:0], in_q[W-1]};
    assign isr_d   = {isr_q[24:0], in_i[W-1]};
    assign fill_d  = (fill_q == 5'd26) ? 5'd26 : fill_q + 5'd1;
    assign match   = ones26(~(qsr_d ^ SOF)) + ones26(~(isr_d ^ EXP_I));
    assign sof_hit = (match >= 6'(THRESH));

`ifdef SOF_PHASE_INV_EN
    logic inv_q;

    // Negation of the most negative code saturates to the most positive one.
    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
        if (x == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
        return -x;
    endfunction

    assign inv_hit = (match <= 6'(52 - THRESH));
    assign pay_i   = inv_q ? neg_sat(in_i) : in_i;
    assign pay_q   = inv_q ? neg_sat(in_q) : in_q;

    always_ff @(posedge clk) begin
        if (rst)
            inv_q <= 1'b0;
        else if (state_q == ST_HUNT && accept && fill_d == 5'd26 && (sof_hit || inv_hit))
            inv_q <= ~sof_hit;
    end
`else
    assign inv_hit = 1'b0;
    assign pay_i   = in_i;
    assign pay_q   = in_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            qsr_q       <= '0;
            isr_q       <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            score_q     <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
        end else begin
            case (state_q)
                ST_HUNT: begin
                    if (accept) begin
                        qsr_q   <= qsr_d;
                        isr_q   <= isr_d;
                        fill_q  <= fill_d;
                        score_q <= match;
                        if (fill_d == 5'd26 && (sof_hit || inv_hit)) state_q <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (accept) begin
                        if (cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
                            state_q <= ST_HUNT;
                            cnt_q   <= '0;
                            fill_q  <= '0;
                            qsr_q   <= '0;
                            isr_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_HUNT;
            endcase

            // Output register: load on a payload accept, drain on out_ready, hold while stalled.
            if (state_q == ST_PAYLOAD && accept) begin
                out_valid_q <= 1'b1;
                out_sof_q   <= (cnt_q == '0);
                out_i_q     <= pay_i;
                out_q_q     <= pay_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign score     = score_q;
    assign locked    = (state_q == ST_PAYLOAD);

endmodule
